// File: rtl/vga_pattern_ctrl.sv
// Sequencing controller for the VGA checkerboard colour datapath.
// Debounces the mode/auto buttons, queues their effects as pending flags and
// applies every datapath-visible change only on the frame_start pulse.
module vga_pattern_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter logic [11:0] COLOR_STEP      = 12'h111,
  parameter logic [11:0] RESET_COLOR     = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_auto,
  input  logic [11:0] sw_color,
  input  logic        frame_start,
  output logic [1:0]  pressed,
  output logic [11:0] color,
  output logic        auto_en,
  output logic        frame_update
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned FcntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FcntW-1:0] FcntLast = FcntW'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} db_state_e;

  // Bit 0 is the mode button, bit 1 the auto button.
  logic [1:0] w_btn;
  logic [1:0] r_sync1, r_sync2;
  logic [1:0] w_press;

  assign w_btn = {btn_auto, btn_mode};

  // Two-flop synchronisers for the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    db_state_e       r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic            w_evt;

    // Debounce state and stability counter.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= S_LOW;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    // Accept a new level after DEBOUNCE_CYCLES equal samples; event only on rise.
    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_evt        = 1'b0;
      case (r_state)
        S_LOW: begin
          if (r_sync2[g]) begin
            w_state_next = S_WAIT_HIGH;
            w_cnt_next   = CntW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (!r_sync2[g]) begin
            w_state_next = S_LOW;
            w_cnt_next   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_next = S_HIGH;
            w_cnt_next   = '0;
            w_evt        = 1'b1;
          end else begin
            w_cnt_next = r_cnt + CntW'(1);
          end
        end
        S_HIGH: begin
          if (!r_sync2[g]) begin
            w_state_next = S_WAIT_LOW;
            w_cnt_next   = CntW'(1);
          end
        end
        S_WAIT_LOW: begin
          if (r_sync2[g]) begin
            w_state_next = S_HIGH;
            w_cnt_next   = '0;
          end else if (r_cnt == CntLast) begin
            w_state_next = S_LOW;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CntW'(1);
          end
        end
        default: begin
          w_state_next = S_LOW;
          w_cnt_next   = '0;
        end
      endcase
    end

    assign w_press[g] = w_evt;
  end

  logic             r_mode_pend, r_auto_pend;
  logic [1:0]       r_pressed, w_pressed_next;
  logic [11:0]      r_color, w_color_next;
  logic             r_auto, w_auto_next;
  logic [FcntW-1:0] r_fcnt, w_fcnt_next;
  logic             r_update, w_update_next;

  // Pending flags: a new event wins over the clear on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode_pend <= 1'b0;
      r_auto_pend <= 1'b0;
    end else begin
      r_mode_pend <= w_press[0] | (r_mode_pend & ~frame_start);
      r_auto_pend <= w_press[1] | (r_auto_pend & ~frame_start);
    end
  end

  // Frame-synchronous next state; all changes use the pre-edge register values.
  always_comb begin
    w_pressed_next = r_pressed;
    w_color_next   = r_color;
    w_auto_next    = r_auto;
    w_fcnt_next    = r_fcnt;
    if (frame_start) begin
      if (r_mode_pend) begin
        w_pressed_next = r_pressed + 2'd1;
      end
      if (!r_auto) begin
        w_color_next = sw_color;
      end else if (r_fcnt == FcntLast) begin
        w_fcnt_next  = '0;
        w_color_next = r_color + COLOR_STEP;
      end else begin
        w_fcnt_next = r_fcnt + FcntW'(1);
      end
      // A toggle restarts the step count, overriding any increment above.
      if (r_auto_pend) begin
        w_auto_next = ~r_auto;
        w_fcnt_next = '0;
      end
    end
    w_update_next = frame_start &
                    ((w_pressed_next != r_pressed) | (w_color_next != r_color));
  end

  // Datapath-visible output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pressed <= '0;
      r_color   <= RESET_COLOR;
      r_auto    <= 1'b0;
      r_fcnt    <= '0;
      r_update  <= 1'b0;
    end else begin
      r_pressed <= w_pressed_next;
      r_color   <= w_color_next;
      r_auto    <= w_auto_next;
      r_fcnt    <= w_fcnt_next;
      r_update  <= w_update_next;
    end
  end

  assign pressed      = r_pressed;
  assign color        = r_color;
  assign auto_en      = r_auto;
  assign frame_update = r_update;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Bench for vga_pattern_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_vga_pattern_ctrl;

  localparam int          D    = 4;
  localparam int          F    = 3;
  localparam int          STEP = 'h111;
  localparam int          RCOL = 'h0F0;
  localparam logic [31:0] HMASK = (32'd1 << D) - 32'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode;
  logic        btn_auto;
  logic [11:0] sw_color;
  logic        frame_start;
  logic [1:0]  pressed;
  logic [11:0] color;
  logic        auto_en;
  logic        frame_update;

  always #5 clk = ~clk;

  vga_pattern_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FRAMES_PER_STEP(F),
    .COLOR_STEP     (12'h111),
    .RESET_COLOR    (12'h0F0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode    (btn_mode),
    .btn_auto    (btn_auto),
    .sw_color    (sw_color),
    .frame_start (frame_start),
    .pressed     (pressed),
    .color       (color),
    .auto_en     (auto_en),
    .frame_update(frame_update)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button level accepted once the last D synchronised
  // samples all disagree with the current accepted level.
  bit          m_s1[2], m_s2[2], m_acc[2], m_pend[2];
  logic [31:0] m_hist[2];
  int          m_pressed, m_color, m_fcnt;
  bit          m_auto, m_upd;

  task automatic model_step();
    bit btn[2];
    bit evt[2];
    int np, nc, nf;
    bit na;
    btn[0] = btn_mode;
    btn[1] = btn_auto;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_acc[i] = 0; m_pend[i] = 0; m_hist[i] = '0;
      end
      m_pressed = 0; m_color = RCOL; m_fcnt = 0; m_auto = 0; m_upd = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        evt[i]    = 0;
        m_hist[i] = {m_hist[i][30:0], m_s2[i]};
        if ((m_hist[i] & HMASK) == (m_acc[i] ? 32'd0 : HMASK)) begin
          m_acc[i] = !m_acc[i];
          evt[i]   = m_acc[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = btn[i];
      end
      m_upd = 0;
      if (frame_start) begin
        np = m_pend[0] ? (m_pressed + 1) % 4 : m_pressed;
        nc = m_color;
        nf = m_fcnt;
        na = m_auto;
        if (!m_auto) begin
          nc = int'(sw_color);
        end else if (m_fcnt == F - 1) begin
          nf = 0;
          nc = (m_color + STEP) % 4096;
        end else begin
          nf = m_fcnt + 1;
        end
        if (m_pend[1]) begin
          na = !m_auto;
          nf = 0;
        end
        m_upd     = (np != m_pressed) || (nc != m_color);
        m_pressed = np;
        m_color   = nc;
        m_fcnt    = nf;
        m_auto    = na;
      end
      for (int i = 0; i < 2; i++) m_pend[i] = evt[i] | (m_pend[i] & !frame_start);
    end
  endtask

  // One clock: inputs already driven; update model, then compare after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("pressed", 32'(pressed), 32'(m_pressed));
    check("color", 32'(color), 32'(m_color));
    check("auto_en", 32'(auto_en), 32'(m_auto));
    check("frame_update", 32'(frame_update), 32'(m_upd));
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; idle(6);
    btn_mode = 1'b0; idle(6);
  endtask

  task automatic press_auto();
    btn_auto = 1'b1; idle(6);
    btn_auto = 1'b0; idle(6);
  endtask

  initial begin
    bit prev_fs;
    rst_n = 1'b0; btn_mode = 1'b0; btn_auto = 1'b0; sw_color = 12'h000; frame_start = 1'b0;

    // Reset held while buttons toggle and frame_start pulses.
    for (int i = 0; i < 3; i++) begin
      btn_mode = i[0]; btn_auto = ~i[0]; frame_start = i[0];
      cyc();
      check("rst_color", 32'(color), 32'h0F0);
    end
    btn_mode = 1'b0; btn_auto = 1'b0; frame_start = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Glitch of 3 synchronised samples is ignored.
    btn_mode = 1'b1; idle(3);
    btn_mode = 1'b0; idle(6);
    frame();
    check("glitch_pressed", 32'(pressed), 32'd0);

    // Long hold gives exactly one press.
    btn_mode = 1'b1; idle(10);
    btn_mode = 1'b0; idle(8);
    frame();
    check("hold_pressed", 32'(pressed), 32'd1);
    check("hold_update", 32'(frame_update), 32'd1);
    idle(2);

    // Saturation then wrap.
    press_mode(); press_mode(); press_mode();
    frame();
    check("sat_pressed", 32'(pressed), 32'd2);
    press_mode(); frame();
    press_mode(); frame();
    check("wrap_pressed", 32'(pressed), 32'd0);

    // Manual colour is sampled only at frame_start.
    sw_color = 12'hABC; idle(2);
    frame();
    check("man_color1", 32'(color), 32'hABC);
    sw_color = 12'h123; idle(3);
    check("man_hold", 32'(color), 32'hABC);
    frame();
    check("man_color2", 32'(color), 32'h123);

    // Auto cycling with 12-bit wrap.
    sw_color = 12'hFFF;
    press_auto();
    frame();
    check("auto_on", 32'(auto_en), 32'd1);
    check("auto_base", 32'(color), 32'hFFF);
    for (int i = 0; i < 2; i++) begin
      idle(3); frame();
      check("auto_nochg", 32'(color), 32'hFFF);
      check("auto_noupd", 32'(frame_update), 32'd0);
    end
    idle(3); frame();
    check("auto_step", 32'(color), 32'h110);
    check("auto_upd", 32'(frame_update), 32'd1);

    // Press event coincident with frame_start applies on the next frame.
    btn_mode = 1'b1; idle(5);
    frame();
    check("coinc_same", 32'(pressed), 32'd0);
    btn_mode = 1'b0; idle(6);
    frame();
    check("coinc_next", 32'(pressed), 32'd1);

    // Reset discards a pending press.
    press_mode();
    rst_n = 1'b0; idle(1);
    rst_n = 1'b1; idle(2);
    frame();
    check("rst_pend", 32'(pressed), 32'd0);

    // Random phase.
    prev_fs = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(5) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(5) == 0) btn_auto = ~btn_auto;
      if ($urandom_range(19) == 0) sw_color = 12'($urandom);
      rst_n = ($urandom_range(499) != 0);
      frame_start = !prev_fs && ($urandom_range(7) == 0);
      prev_fs = frame_start;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_pattern_ctrl.md
Name: vga_pattern_ctrl

Overview:
Sequencing controller for the VGA checkerboard colour datapath. Debounces two board buttons and drives the datapath's 2-bit orientation select (`pressed`) and 12-bit base colour (`in`). In auto mode it steps the colour every N frames. All datapath-visible changes are applied only on the frame-start pulse from the timing generator, so no frame ever shows a mid-frame change. Runs in the pixel clock domain, between the button pins / timing generator and the colour datapath.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a new button level (10 ms at 25 MHz); minimum 2
FRAMES_PER_STEP, 30, frame_start pulses per auto colour step; minimum 1
COLOR_STEP, 12'h111, value added to the colour on each auto step
RESET_COLOR, 12'h0F0, colour output value after reset

Ports:
clk  input  1  pixel clock; the only clock
rst_n  input  1  reset, synchronous, active-low
btn_mode  input  1  raw asynchronous button; each press advances the orientation
btn_auto  input  1  raw asynchronous button; each press toggles auto mode
sw_color  input  12  manual colour from the switches, RGB 4:4:4
frame_start  input  1  single-cycle pulse from the timing generator at the start of vertical blank
pressed  output  2  orientation select to the colour datapath
color  output  12  base colour to the colour datapath
auto_en  output  1  auto-cycle mode indicator (LED)
frame_update  output  1  single-cycle pulse in the cycle after any frame_start on which pressed or color changed value

Behaviour:
- Reset: rst_n is sampled on the clk rising edge. While rst_n=0, every register is cleared on each edge:
  - pressed=0, color=RESET_COLOR, auto_en=0, frame_update=0
  - synchronisers=0, debounce FSMs in S_LOW with counter 0
  - pending flags=0, frame counter=0
- Reset mid-operation discards pending presses and any partial debounce count.
- Synchronisation: each button passes through a 2-flop synchroniser. Debounce logic sees only the second flop.
- Debounce FSM, one instance per button:
  - States: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW.
  - S_LOW: when sync=1, go to S_WAIT_HIGH with cnt=1.
  - S_WAIT_HIGH:
    - sync=0 returns to S_LOW.
    - Otherwise cnt increments.
    - When cnt reaches DEBOUNCE_CYCLES-1 with sync=1, go to S_HIGH and emit a one-cycle press event in the transition cycle.
  - S_HIGH and S_WAIT_LOW are symmetric, with no event on release.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no event.
  - A press event occurs once per accepted rising level, regardless of how long the button is held.
- Pending flags:
  - A mode press event sets mode_pend; an auto press event sets auto_pend.
  - Flags saturate: any number of presses between two frame_starts counts as one.
- Frame_start processing, using the register values present at the edge. All updates below take effect together on that edge.
  - If mode_pend: pressed <= pressed+1 (mod 4, so 3 wraps to 0); clear mode_pend.
  - If auto_pend: auto_en <= ~auto_en; frame counter <= 0; clear auto_pend.
  - Colour, using the old auto_en:
    - If auto_en=0: color <= sw_color.
    - If auto_en=1: when fcnt==FRAMES_PER_STEP-1, fcnt <= 0 and color <= color+COLOR_STEP (12-bit truncating add, e.g. 12'hFFF+12'h111=12'h110); otherwise fcnt <= fcnt+1.
    - The counter reset from a toggle overrides the auto increment in the same cycle.
- Simultaneous press event and frame_start in the same cycle: the flag is set on that edge and applied at the next frame_start. A flag is never set and cleared on the same edge.
- Timing of changes:
  - Outputs change only on the edge that samples frame_start=1. Latency from a press event to the output change is up to one frame.
  - frame_update=1 in the cycle after such an edge if pressed or color changed value; otherwise 0.
- sw_color changes between frame_starts have no effect until the next frame_start.
- frame_start held high for several cycles counts as one event per cycle. This is out of spec; the timing generator guarantees single-cycle pulses.

Test Plan:
(All with DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=3.)
- Reset: hold rst_n=0 for 3 cycles while toggling buttons and pulsing frame_start -> pressed=0, color=12'h0F0, auto_en=0, frame_update=0 throughout and after release.
- Debounce: btn_mode high for 3 synchronised cycles, then 0, then frame_start -> pressed stays 0. Hold high for 10 cycles, then frame_start -> pressed=1, frame_update pulses once.
- Saturation and wrap: three accepted mode presses, then one frame_start -> pressed increments by 1 only. From pressed=3, one press plus frame_start -> pressed=0.
- Manual colour: auto_en=0, sw_color=12'hABC, change to 12'h123 mid-frame -> color=12'hABC after the first frame_start, 12'h123 only after the next frame_start.
- Auto cycling: auto press, frame_start (auto_en=1, fcnt=0), color=12'hFFF -> after 3 more frame_starts color=12'h110. Pulses 1–2 show no change and frame_update=0.
- Coincidence and mid-op reset: press event in the same cycle as frame_start -> no change on that frame, change on the next. Set mode_pend, assert rst_n=0 for 1 cycle, then frame_start -> pressed=0.
